// File: rtl/booth_mult_engine.sv
// booth_mult_engine
//   Sequential radix-4 Booth multiplier datapath. It computes a signed
//   WIDTH x WIDTH product in WIDTH/2 iteration cycles. The Booth recoder is
//   an external combinational block. It reads prod_window[2:0] and returns
//   booth_pm/booth_shift. This engine owns all of the state.
//
// Ports
//   clock           in   rising-edge clock
//   resetn          in   asynchronous active-low reset
//   ctrl_MULT       in   start pulse; loads operands on any state (restart)
//   data_operandA   in   multiplicand, signed
//   data_operandB   in   multiplier, signed
//   booth_pm        in   recoder op: 00 none, 01 subtract, 10 add, 11 none
//   booth_shift     in   recoder: 1 selects multiplicand<<1
//   prod_window     out  {hi[WIDTH-2:0], lo, ext} seen by the recoder
//   data_result     out  low word of the product, held until next load
//   data_exception  out  signed overflow of the low-word result
//   data_resultRDY  out  one-cycle done strobe
//   busy            out  high while iterating
module booth_mult_engine #(
  parameter int WIDTH = 32,
  parameter int ITERS = WIDTH / 2
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 ctrl_MULT,
  input  logic [WIDTH-1:0]     data_operandA,
  input  logic [WIDTH-1:0]     data_operandB,
  input  logic [1:0]           booth_pm,
  input  logic                 booth_shift,
  output logic [2*WIDTH-1:0]   prod_window,
  output logic [WIDTH-1:0]     data_result,
  output logic                 data_exception,
  output logic                 data_resultRDY,
  output logic                 busy
);

  localparam int CW = $clog2(ITERS) + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       r_state;
  // The accumulator has two guard bits, so adding or subtracting 2*mcand cannot overflow.
  logic [WIDTH+1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_ext;
  logic [WIDTH+1:0] r_mcand;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_exc;
  logic             r_rdy;
  logic             r_busy;

  logic [WIDTH+1:0] w_addend;
  logic [WIDTH+1:0] w_sum;
  logic [WIDTH+1:0] w_next_hi;
  logic [WIDTH-1:0] w_next_lo;
  logic             w_next_ext;
  logic             w_ovf;
  logic             w_last;

  // Datapath for one Booth step: add or subtract the partial product, then shift right by two.
  always_comb begin
    w_addend = booth_shift ? {r_mcand[WIDTH:0], 1'b0} : r_mcand;
    case (booth_pm)
      2'b10:   w_sum = r_hi + w_addend;
      2'b01:   w_sum = r_hi - w_addend;
      default: w_sum = r_hi;
    endcase
    w_next_hi  = {{2{w_sum[WIDTH+1]}}, w_sum[WIDTH+1:2]};
    w_next_lo  = {w_sum[1:0], r_lo[WIDTH-1:2]};
    w_next_ext = r_lo[1];
    // The result overflows unless the whole upper part is a sign extension of the low word.
    w_ovf      = |(w_next_hi ^ {(WIDTH+2){w_next_lo[WIDTH-1]}});
    w_last     = (r_cnt == CW'(ITERS - 1));
  end

  // Control FSM, iteration state and output registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state  <= ST_IDLE;
      r_hi     <= '0;
      r_lo     <= '0;
      r_ext    <= 1'b0;
      r_mcand  <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
      r_busy   <= 1'b0;
    end else if (ctrl_MULT) begin
      // A load in any state aborts the current operation without a done strobe.
      r_state  <= ST_RUN;
      r_hi     <= '0;
      r_lo     <= data_operandB;
      r_ext    <= 1'b0;
      r_mcand  <= {{2{data_operandA[WIDTH-1]}}, data_operandA};
      r_cnt    <= '0;
      r_result <= '0;
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
      r_busy   <= 1'b1;
    end else begin
      case (r_state)
        ST_RUN: begin
          r_hi  <= w_next_hi;
          r_lo  <= w_next_lo;
          r_ext <= w_next_ext;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_state  <= ST_DONE;
            r_result <= w_next_lo;
            r_exc    <= w_ovf;
            r_rdy    <= 1'b1;
            r_busy   <= 1'b0;
          end else begin
            r_state  <= ST_RUN;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_rdy   <= 1'b0;
        end
        ST_IDLE: begin
          r_state <= ST_IDLE;
          r_rdy   <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_rdy   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign prod_window    = {r_hi[WIDTH-2:0], r_lo, r_ext};
  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;
  assign busy           = r_busy;

endmodule

// File: doc/booth_mult_engine.md
Name: booth_mult_engine

Overview:
- Sequential radix-4 Booth multiplier datapath. It consumes the plus/minus and shift recode issued by the Booth recoding unit, and drives that unit's 64-bit product window.
- Computes the signed 32x32 product in 16 iteration cycles.
- Returns the low 32 bits and flags overflow to the ALU/multdiv wrapper.
- The recoder stays a separate combinational block; this engine owns all state.

Parameters:
- WIDTH, 32, operand/result width (must be even; iterations = WIDTH/2).
- ITERS, 16, Booth iterations, fixed at WIDTH/2.

Ports:
- clock  in  1  rising-edge clock.
- resetn  in  1  asynchronous, active-low reset.
- ctrl_MULT  in  1  start pulse; operands are sampled on this edge.
- data_operandA  in  32  multiplicand, signed.
- data_operandB  in  32  multiplier, signed.
- booth_pm  in  2  from recoder: 00 none, 01 subtract, 10 add, 11 treated as none.
- booth_shift  in  1  from recoder: 1 selects multiplicand<<1.
- prod_window  out  64  to recoder: {hi[30:0], lo[31:0], ext}; the recoder uses bits [2:0] = {lo[1:0], ext}.
- data_result  out  32  product low word.
- data_exception  out  1  signed overflow of the 32-bit result.
- data_resultRDY  out  1  one-cycle done strobe.
- busy  out  1  high in RUN.

Behaviour:
- State:
  - hi[33:0]: signed accumulator, 34 bits so that ±2M cannot overflow.
  - lo[31:0]: multiplier/low product.
  - ext: implicit Booth bit.
  - mcand[33:0]: sign-extended multiplicand.
  - cnt[4:0]: iteration counter.
  - FSM {IDLE, RUN, DONE}.
- Reset (resetn low, asynchronous):
  - FSM=IDLE; hi, lo, ext, mcand and cnt all 0.
  - All outputs 0 (prod_window=0, data_result=0, data_exception=0, data_resultRDY=0, busy=0).
- Load: on the edge where ctrl_MULT=1, in any state:
  - hi=0, lo=data_operandB, ext=0, mcand=sext(data_operandA), cnt=0.
  - FSM goes to RUN. This edge is E0.
- Restart: ctrl_MULT high in RUN or DONE aborts the current operation and reloads as above. There is no RDY for the aborted operation.
- RUN step (each edge E1..E16):
  - addend = booth_shift ? mcand<<1 : mcand, computed at 34 bits.
  - sum = hi + addend for pm=10; hi - addend for pm=01; hi for pm=00 or 11.
  - Shift {sum, lo, ext} arithmetic-right by 2 (sign from sum[33]) into {hi, lo, ext}.
  - cnt increments.
  - On the step where cnt==15 before the edge (E16), go to DONE.
- DONE (cycle after E16):
  - data_resultRDY=1 for exactly one cycle, then IDLE.
  - data_result=lo.
  - data_exception=1 iff any bit of hi[33:0] differs from lo[31].
- data_result and data_exception are registered at E16 and held until the next load or reset. At load they clear to 0.
- Latency: ctrl_MULT sampled at E0 -> data_resultRDY high in the cycle following E16 (17 clocks).
- busy is high from after E0 through E16; it is low in DONE and IDLE.
- In IDLE, booth_pm and booth_shift are ignored and the registers hold.
- Arithmetic: all signed two's complement; no saturation. Result wraps to the low 32 bits.

Test Plan:
- A=3, B=5, one ctrl_MULT pulse -> RDY exactly 17 clocks later; data_result=0x0000000F, data_exception=0; busy high for 16 cycles.
- A=-7 (0xFFFFFFF9), B=6 -> data_result=0xFFFFFFD6 (-42), exception=0. Also A=0x80000000, B=1 -> 0x80000000, exception=0.
- A=0x7FFFFFFF, B=2 -> data_result=0xFFFFFFFE, exception=1. A=0x80000000, B=0xFFFFFFFF -> data_result=0x80000000, exception=1.
- Start A=3, B=5; pulse ctrl_MULT again at E8 with A=4, B=4 -> one RDY only, 17 clocks after the second pulse, data_result=0x10.
- Start A=9, B=9; drive resetn low asynchronously mid-cycle at E5 -> all outputs 0 immediately, FSM IDLE, no RDY. After release, A=9, B=9 -> 0x51.
- Random signed pairs (1000 runs, including 0, ±1, min and max) with the real recoder attached -> data_result equals the low 32 bits of the reference product. data_exception equals (64-bit product ≠ sext of its low 32 bits).
